// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the digital-lock sequencer.
//   lock_state_e : FSM state encoding, also the value presented on state_o
//   attempts_w() : width of the consecutive-failure counter for a given MAX_TRIES
//   timer_w()    : width of a down-counter able to hold the larger of two cycle counts minus one
package lock_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_LOCKOUT = 3'd5,
        ST_PROG    = 3'd6
    } lock_state_e;

    function automatic int unsigned attempts_w(input int unsigned max_tries);
        return (max_tries < 1) ? 1 : $clog2(max_tries + 1);
    endfunction

    function automatic int unsigned timer_w(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter shared by the OPEN and LOCKOUT hold periods.
//   clk, rstn   : clock, asynchronous active-low reset
//   load_i      : load load_val_i (takes priority over en_i)
//   load_val_i  : value loaded into the counter
//   en_i        : decrement while non-zero
//   done_o      : counter has reached zero
module lock_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: keypad entry / code comparison controller for the digital lock.
// Collects digits, checks them against the stored code, drives unlock / error /
// lockout indications and enforces a timed lockout after MAX_TRIES failures.
// Optional build macro: LOCK_SEQ_PROGRAM_EN enables code reprogramming from OPEN
// via prog_i; without it the code is the constant DEFAULT_CODE.
//   clk, rstn     : clock, asynchronous active-low reset
//   key_valid_i   : strobe, key_digit_i holds an entered digit
//   key_digit_i   : entered digit
//   enter_i       : strobe, submit the entry
//   clear_i       : strobe, discard the entry
//   prog_i        : request reprogramming (only with LOCK_SEQ_PROGRAM_EN)
//   unlocked_o    : lock open
//   err_o         : one-cycle wrong-code indication
//   lockout_o     : lockout active
//   attempts_o    : consecutive failure count
//   state_o       : current FSM state (debug)
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned                  CODE_LEN       = 4,
    parameter int unsigned                  DIGIT_W        = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]  DEFAULT_CODE   = 16'h1234,
    parameter int unsigned                  MAX_TRIES      = 3,
    parameter int unsigned                  UNLOCK_CYCLES  = 8,
    parameter int unsigned                  LOCKOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              key_valid_i,
    input  logic [DIGIT_W-1:0]                key_digit_i,
    input  logic                              enter_i,
    input  logic                              clear_i,
    input  logic                              prog_i,
    output logic                              unlocked_o,
    output logic                              err_o,
    output logic                              lockout_o,
    output logic [attempts_w(MAX_TRIES)-1:0]  attempts_o,
    output logic [STATE_W-1:0]                state_o
);

    localparam int unsigned CODE_W = CODE_LEN * DIGIT_W;
    localparam int unsigned CNT_W  = $clog2(CODE_LEN + 1);
    localparam int unsigned ATT_W  = attempts_w(MAX_TRIES);
    localparam int unsigned TMR_W  = timer_w(UNLOCK_CYCLES, LOCKOUT_CYCLES);

    lock_state_e         state_q, state_d;
    logic [CODE_W-1:0]   buf_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovr_q;
    logic [ATT_W-1:0]    attempts_q;
    logic [CODE_W-1:0]   code_q;

    logic                do_clear, do_enter, do_key;
    logic                prog_req;
    logic                full;
    logic                match;
    logic                last_try;
    logic                tmr_load, tmr_en, tmr_done;
    logic [TMR_W-1:0]    tmr_load_val;

    // Strobe priority: clear > enter > key; lower strobes in the same cycle are dropped.
    assign do_clear = clear_i;
    assign do_enter = enter_i & ~clear_i;
    assign do_key   = key_valid_i & ~enter_i & ~clear_i;

`ifdef LOCK_SEQ_PROGRAM_EN
    assign prog_req = prog_i;
`else
    logic unused_prog;
    assign unused_prog = prog_i;
    assign prog_req    = 1'b0;
`endif

    assign full     = (cnt_q == CNT_W'(CODE_LEN));
    assign match    = full && !ovr_q && (buf_q == code_q);
    assign last_try = ((attempts_q + ATT_W'(1)) == ATT_W'(MAX_TRIES));

    // The timer is loaded while in CHECK with the hold period of whichever
    // timed state follows; a mismatch that only leads to FAIL loads harmlessly.
    assign tmr_load     = (state_q == ST_CHECK);
    assign tmr_load_val = match ? TMR_W'(UNLOCK_CYCLES - 1) : TMR_W'(LOCKOUT_CYCLES - 1);
    // PROG leaves tmr_en low, freezing the unlock timer.
    assign tmr_en       = (state_q == ST_OPEN) || (state_q == ST_LOCKOUT);

    lock_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .done_o     (tmr_done)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (do_enter) begin
                    state_d = ST_CHECK;
                end else if (do_key) begin
                    state_d = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (do_clear) begin
                    state_d = ST_IDLE;
                end else if (do_enter) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (match) begin
                    state_d = ST_OPEN;
                end else if (last_try) begin
                    state_d = ST_LOCKOUT;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
            end
            ST_OPEN: begin
                if (prog_req) begin
                    state_d = ST_PROG;
                end else if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROG: begin
                if (do_clear || do_enter) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode (Moore)
    always_comb begin
        unlocked_o = (state_q == ST_OPEN) || (state_q == ST_PROG);
        err_o      = (state_q == ST_FAIL);
        lockout_o  = (state_q == ST_LOCKOUT);
        attempts_o = attempts_q;
        state_o    = state_q;
    end

    // Entry buffer, digit count, overrun flag and failure counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_q      <= '0;
            cnt_q      <= '0;
            ovr_q      <= 1'b0;
            attempts_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (do_key) begin
                        buf_q <= CODE_W'(key_digit_i);
                        cnt_q <= CNT_W'(1);
                    end
                end
                ST_ENTRY, ST_PROG: begin
                    if (do_clear) begin
                        buf_q <= '0;
                        cnt_q <= '0;
                        ovr_q <= 1'b0;
                    end else if (do_enter) begin
                        // ENTRY keeps the buffer for CHECK; PROG is done with it.
                        if (state_q == ST_PROG) begin
                            buf_q <= '0;
                            cnt_q <= '0;
                            ovr_q <= 1'b0;
                        end
                    end else if (do_key) begin
                        if (full) begin
                            ovr_q <= 1'b1;
                        end else begin
                            buf_q <= (buf_q << DIGIT_W) | CODE_W'(key_digit_i);
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    buf_q <= '0;
                    cnt_q <= '0;
                    ovr_q <= 1'b0;
                    if (match) begin
                        attempts_q <= '0;
                    end else if (attempts_q != ATT_W'(MAX_TRIES)) begin
                        attempts_q <= attempts_q + 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (tmr_done) begin
                        attempts_q <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stored code
`ifdef LOCK_SEQ_PROGRAM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            code_q <= DEFAULT_CODE;
        end else if ((state_q == ST_PROG) && do_enter && full && !ovr_q) begin
            code_q <= buf_q;
        end
    end
`else
    assign code_q = DEFAULT_CODE;
`endif

endmodule
